// File: rtl/uart_prog_loader_if.sv
// Loader bus: UART byte stream and reload request in, instruction RAM write port and status out.
// The loader itself connects through the slave modport; the byte source/observer uses master.
interface uart_prog_loader_if #(
    parameter int unsigned NBIT_DATA_LEN = 8,
    parameter int unsigned len_data      = 32,
    parameter int unsigned len_addr      = 11
);
    logic                     rx_done_tick;
    logic [NBIT_DATA_LEN-1:0] rx_data_in;
    logic                     load_req;
    logic [len_addr-1:0]      addr_mem_inst;
    logic [len_data-1:0]      ins_to_mem;
    logic                     wr_ram_inst;
    logic                     ctrl_clk_mips;
    logic                     load_done;
    logic                     load_err;
    logic [len_addr:0]        word_count;

    modport master (
        output rx_done_tick,
        output rx_data_in,
        output load_req,
        input  addr_mem_inst,
        input  ins_to_mem,
        input  wr_ram_inst,
        input  ctrl_clk_mips,
        input  load_done,
        input  load_err,
        input  word_count
    );

    modport slave (
        input  rx_done_tick,
        input  rx_data_in,
        input  load_req,
        output addr_mem_inst,
        output ins_to_mem,
        output wr_ram_inst,
        output ctrl_clk_mips,
        output load_done,
        output load_err,
        output word_count
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Assembles UART bytes (MSB first) into instruction words, writes them to instruction RAM from
// address 0 until the halt word, then enables the MIPS clock. All outputs are registered.
module uart_prog_loader #(
    parameter int unsigned          NBIT_DATA_LEN = 8,
    parameter int unsigned          len_data      = 32,
    parameter int unsigned          len_addr      = 11,
    parameter logic [len_data-1:0]  HALT_WORD     = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    uart_prog_loader_if.slave bus_io
);
    typedef enum logic [1:0] {StRecv, StWrite, StDone, StErr} state_e;

    localparam logic [1:0] LastIdx = 2'd3;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [len_data-1:0] asm_q, asm_d;
    logic [len_data-1:0] ins_q, ins_d;
    logic [len_addr-1:0] addr_q, addr_d;
    logic [len_addr:0]   count_q, count_d;
    logic                wr_q, wr_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                tick;
    logic                last_byte;
    logic                is_halt;
    logic                addr_full;
    logic [len_data-1:0] asm_shift;

    assign tick      = bus_io.rx_done_tick;
    assign last_byte = tick && (idx_q == LastIdx);
    assign is_halt   = (ins_q == HALT_WORD);
    assign addr_full = (addr_q == '1);
    assign asm_shift = {asm_q[len_data-NBIT_DATA_LEN-1:0], bus_io.rx_data_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRecv;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRecv: begin
                if (last_byte) state_d = StWrite;
            end
            StWrite: begin
                if (is_halt)        state_d = StDone;
                else if (addr_full) state_d = StErr;
                else                state_d = StRecv;
            end
            StDone, StErr: begin
                if (bus_io.load_req) state_d = StRecv;
            end
            default: state_d = StRecv;
        endcase
    end

    // Registered outputs follow the state being entered so they line up with state_q.
    always_comb begin
        wr_d   = (state_d == StWrite);
        run_d  = (state_d == StDone);
        done_d = (state_d == StDone);
        err_d  = (state_d == StErr);
    end

    always_comb begin
        idx_d   = idx_q;
        asm_d   = asm_q;
        ins_d   = ins_q;
        addr_d  = addr_q;
        count_d = count_q;
        unique case (state_q)
            StRecv: begin
                if (tick) begin
                    asm_d = asm_shift;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LastIdx) ins_d = asm_shift;
                end
            end
            StWrite: begin
                count_d = count_q + (len_addr + 1)'(1);
                // A byte arriving now starts the next word, unless loading ends here.
                if (!is_halt && !addr_full) begin
                    addr_d = addr_q + len_addr'(1);
                    if (tick) begin
                        asm_d = asm_shift;
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDone, StErr: begin
                if (bus_io.load_req) begin
                    addr_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    asm_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            asm_q   <= '0;
            ins_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            wr_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ins_q   <= ins_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus_io.addr_mem_inst = addr_q;
    assign bus_io.ins_to_mem    = ins_q;
    assign bus_io.wr_ram_inst   = wr_q;
    assign bus_io.ctrl_clk_mips = run_q;
    assign bus_io.load_done     = done_q;
    assign bus_io.load_err      = err_q;
    assign bus_io.word_count    = count_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader: a default instance and a 4-word RAM instance, checked
// against a byte-stream model that groups bytes into words and applies the halt/full rules.
module tb_uart_prog_loader;
    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_prog_loader_if #(.len_addr(11)) bus_a ();
    uart_prog_loader_if #(.len_addr(2))  bus_b ();

    uart_prog_loader #(.len_addr(11)) dut_a (.clk(clk), .reset(reset), .bus_io(bus_a.slave));
    uart_prog_loader #(.len_addr(2))  dut_b (.clk(clk), .reset(reset), .bus_io(bus_b.slave));

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sent_a[$];
    logic [7:0] sent_b[$];
    wr_t        log_a[$];
    wr_t        log_b[$];
    wr_t        exp_q[$];
    bit         exp_done;
    bit         exp_err;

    always @(negedge clk) begin
        if (bus_a.wr_ram_inst === 1'b1)
            log_a.push_back(wr_t'({bus_a.addr_mem_inst, bus_a.ins_to_mem}));
        if (bus_b.wr_ram_inst === 1'b1)
            log_b.push_back(wr_t'({9'd0, bus_b.addr_mem_inst, bus_b.ins_to_mem}));
    end

    // Reference: every accepted byte joins a word MSB first; words go to consecutive
    // addresses from 0; loading stops after the halt word or after the last address.
    task automatic build_model(input bit sel);
        logic [7:0]  s[$];
        int          cap;
        logic [31:0] w;
        if (sel) begin s = sent_b; cap = 4; end
        else     begin s = sent_a; cap = 2048; end
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i + 3 < s.size(); i += 4) begin
            if (exp_done || exp_err) break;
            w = {s[i], s[i+1], s[i+2], s[i+3]};
            exp_q.push_back(wr_t'({11'(i / 4), w}));
            if (w == 32'hFFFF_FFFF) exp_done = 1'b1;
            else if (i / 4 == cap - 1) exp_err = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_word();
        return {8'($urandom_range(254, 0)), 24'($urandom)};
    endfunction

    task automatic send(input bit sel, input logic [7:0] b, input int unsigned gap);
        if (sel) begin
            bus_b.rx_data_in = b; bus_b.rx_done_tick = 1'b1; sent_b.push_back(b);
        end else begin
            bus_a.rx_data_in = b; bus_a.rx_done_tick = 1'b1; sent_a.push_back(b);
        end
        @(posedge clk); #1;
        bus_a.rx_done_tick = 1'b0; bus_a.rx_data_in = 8'($urandom);
        bus_b.rx_done_tick = 1'b0; bus_b.rx_data_in = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input int unsigned maxgap,
                             input bit last_tight);
        for (int k = 0; k < 4; k++)
            send(sel, w[31-8*k -: 8],
                 (last_tight && k == 3) ? 32'd0 : $urandom_range(maxgap, 0));
    endtask

    task automatic pulse_req(input bit sel, input bit with_tick, input logic [7:0] b);
        if (sel) begin
            bus_b.load_req = 1'b1; bus_b.rx_done_tick = with_tick; bus_b.rx_data_in = b;
        end else begin
            bus_a.load_req = 1'b1; bus_a.rx_done_tick = with_tick; bus_a.rx_data_in = b;
        end
        @(posedge clk); #1;
        bus_a.load_req = 1'b0; bus_a.rx_done_tick = 1'b0;
        bus_b.load_req = 1'b0; bus_b.rx_done_tick = 1'b0;
    endtask

    task automatic restart_a();
        pulse_req(1'b0, 1'b0, 8'h00);
        sent_a.delete();
        log_a.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (bus_a.addr_mem_inst !== 11'd0) $display("FAIL rst_addr got=%h exp=0", bus_a.addr_mem_inst); else n_pass++;
        n_checks++; if (bus_a.ins_to_mem !== 32'd0) $display("FAIL rst_ins got=%h exp=0", bus_a.ins_to_mem); else n_pass++;
        n_checks++; if (bus_a.wr_ram_inst !== 1'b0) $display("FAIL rst_wr got=%b exp=0", bus_a.wr_ram_inst); else n_pass++;
        n_checks++; if (bus_a.ctrl_clk_mips !== 1'b0) $display("FAIL rst_clk got=%b exp=0", bus_a.ctrl_clk_mips); else n_pass++;
        n_checks++; if (bus_a.load_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus_a.load_done); else n_pass++;
        n_checks++; if (bus_a.load_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus_a.load_err); else n_pass++;
        n_checks++; if (bus_a.word_count !== 12'd0) $display("FAIL rst_wc got=%0d exp=0", bus_a.word_count); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        wr_t got;
        send_word(1'b0, 32'h2001_0005, 3, 1'b0);
        send_word(1'b0, 32'hFFFF_FFFF, 2, 1'b1);
        @(negedge clk);
        n_checks++; if (bus_a.wr_ram_inst !== 1'b1) $display("FAIL basic_wr got=%b exp=1", bus_a.wr_ram_inst); else n_pass++;
        n_checks++; if (bus_a.addr_mem_inst !== 11'd1) $display("FAIL basic_addr got=%0d exp=1", bus_a.addr_mem_inst); else n_pass++;
        n_checks++; if (bus_a.ctrl_clk_mips !== 1'b0) $display("FAIL basic_clk_early got=%b exp=0", bus_a.ctrl_clk_mips); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus_a.ctrl_clk_mips !== 1'b1) $display("FAIL basic_clk got=%b exp=1", bus_a.ctrl_clk_mips); else n_pass++;
        n_checks++; if (bus_a.wr_ram_inst !== 1'b0) $display("FAIL basic_wr_drop got=%b exp=0", bus_a.wr_ram_inst); else n_pass++;
        n_checks++; if (bus_a.word_count !== 12'd2) $display("FAIL basic_wc got=%0d exp=2", bus_a.word_count); else n_pass++;
        @(posedge clk); #1;
        // Ticks in DONE must not write anything.
        send_word(1'b0, rand_word(), 1, 1'b0);
        repeat (2) @(posedge clk); #1;
        build_model(1'b0);
        n_checks++; if (bus_a.load_done !== exp_done) $display("FAIL basic_done got=%b exp=%b", bus_a.load_done, exp_done); else n_pass++;
        n_checks++; if (bus_a.word_count !== 12'd2) $display("FAIL done_ignore_wc got=%0d exp=2", bus_a.word_count); else n_pass++;
        n_checks++; if (log_a.size() != exp_q.size()) $display("FAIL basic_nwr got=%0d exp=%0d", log_a.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_a.size()) ? log_a[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL basic_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        got = (log_a.size() > 0) ? log_a[0] : '0;
        n_checks++; if (got.data !== 32'h2001_0005) $display("FAIL basic_word0 got=%h exp=20010005", got.data); else n_pass++;
    endtask

    task automatic test_reload();
        wr_t got;
        pulse_req(1'b0, 1'b1, 8'h99);
        sent_a.delete();
        log_a.delete();
        @(negedge clk);
        n_checks++; if (bus_a.ctrl_clk_mips !== 1'b0) $display("FAIL reload_clk got=%b exp=0", bus_a.ctrl_clk_mips); else n_pass++;
        n_checks++; if (bus_a.load_done !== 1'b0) $display("FAIL reload_done got=%b exp=0", bus_a.load_done); else n_pass++;
        n_checks++; if (bus_a.word_count !== 12'd0) $display("FAIL reload_wc0 got=%0d exp=0", bus_a.word_count); else n_pass++;
        n_checks++; if (bus_a.addr_mem_inst !== 11'd0) $display("FAIL reload_addr got=%0d exp=0", bus_a.addr_mem_inst); else n_pass++;
        @(posedge clk); #1;
        send_word(1'b0, 32'h1122_3344, 1, 1'b1);
        @(negedge clk);
        n_checks++; if (bus_a.ctrl_clk_mips !== 1'b0) $display("FAIL reload_clk_wr got=%b exp=0", bus_a.ctrl_clk_mips); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus_a.word_count !== 12'd1) $display("FAIL reload_wc1 got=%0d exp=1", bus_a.word_count); else n_pass++;
        @(posedge clk); #1;
        send_word(1'b0, 32'hFFFF_FFFF, 1, 1'b1);
        repeat (3) @(posedge clk); #1;
        build_model(1'b0);
        n_checks++; if (bus_a.word_count !== 12'd2) $display("FAIL reload_wc2 got=%0d exp=2", bus_a.word_count); else n_pass++;
        n_checks++; if (bus_a.load_done !== exp_done) $display("FAIL reload_fin got=%b exp=%b", bus_a.load_done, exp_done); else n_pass++;
        n_checks++; if (log_a.size() != exp_q.size()) $display("FAIL reload_nwr got=%0d exp=%0d", log_a.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_a.size()) ? log_a[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL reload_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        got = (log_a.size() > 0) ? log_a[0] : '0;
        n_checks++; if (got.data !== 32'h1122_3344) $display("FAIL reload_word0 got=%h exp=11223344", got.data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        wr_t got;
        int unsigned n;
        restart_a();
        send_word(1'b0, rand_word(), 0, 1'b1);
        send_word(1'b0, 32'hAABB_CCDD, 0, 1'b0);
        n = $urandom_range(6, 3);
        for (int k = 0; k < int'(n); k++) send_word(1'b0, rand_word(), 2, 1'($urandom_range(1, 0)));
        send_word(1'b0, 32'hFFFF_FFFF, 0, 1'b1);
        repeat (3) @(posedge clk); #1;
        build_model(1'b0);
        n_checks++; if (bus_a.word_count !== 12'(n + 3)) $display("FAIL b2b_wc got=%0d exp=%0d", bus_a.word_count, n + 3); else n_pass++;
        n_checks++; if (bus_a.load_done !== exp_done) $display("FAIL b2b_done got=%b exp=%b", bus_a.load_done, exp_done); else n_pass++;
        n_checks++; if (log_a.size() != exp_q.size()) $display("FAIL b2b_nwr got=%0d exp=%0d", log_a.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_a.size()) ? log_a[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL b2b_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        got = (log_a.size() > 1) ? log_a[1] : '0;
        n_checks++; if (got.data !== 32'hAABB_CCDD) $display("FAIL b2b_word1 got=%h exp=aabbccdd", got.data); else n_pass++;
    endtask

    task automatic test_req_mid_word();
        wr_t got;
        restart_a();
        send_word(1'b0, rand_word(), 1, 1'b0);
        send(1'b0, 8'($urandom_range(254, 0)), 1);
        send(1'b0, 8'($urandom), 0);
        pulse_req(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        n_checks++; if (bus_a.word_count !== 12'd1) $display("FAIL midreq_wc got=%0d exp=1", bus_a.word_count); else n_pass++;
        n_checks++; if (bus_a.addr_mem_inst !== 11'd1) $display("FAIL midreq_addr got=%0d exp=1", bus_a.addr_mem_inst); else n_pass++;
        @(posedge clk); #1;
        send(1'b0, 8'($urandom), 1);
        send(1'b0, 8'($urandom), 2);
        send_word(1'b0, 32'hFFFF_FFFF, 1, 1'b1);
        repeat (3) @(posedge clk); #1;
        build_model(1'b0);
        n_checks++; if (bus_a.word_count !== 12'd3) $display("FAIL midreq_wc3 got=%0d exp=3", bus_a.word_count); else n_pass++;
        n_checks++; if (log_a.size() != exp_q.size()) $display("FAIL midreq_nwr got=%0d exp=%0d", log_a.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_a.size()) ? log_a[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL midreq_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        wr_t         got;
        logic [31:0] w;
        restart_a();
        send_word(1'b0, rand_word(), 0, 1'b1);
        #1;
        n_checks++; if (bus_a.wr_ram_inst !== 1'b1) $display("FAIL rstwr_pre got=%b exp=1", bus_a.wr_ram_inst); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (bus_a.wr_ram_inst !== 1'b0) $display("FAIL rstwr_drop got=%b exp=0", bus_a.wr_ram_inst); else n_pass++;
        n_checks++; if (bus_a.ins_to_mem !== 32'd0) $display("FAIL rstwr_ins got=%h exp=0", bus_a.ins_to_mem); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        sent_a.delete();
        log_a.delete();
        for (int k = 0; k < 3; k++) send_word(1'b0, rand_word(), 1, 1'b0);
        send(1'b0, 8'($urandom), 0);
        send(1'b0, 8'($urandom), 0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus_a.addr_mem_inst !== 11'd0) $display("FAIL rstmid_addr got=%0d exp=0", bus_a.addr_mem_inst); else n_pass++;
        n_checks++; if (bus_a.word_count !== 12'd0) $display("FAIL rstmid_wc got=%0d exp=0", bus_a.word_count); else n_pass++;
        n_checks++; if (bus_a.ins_to_mem !== 32'd0) $display("FAIL rstmid_ins got=%h exp=0", bus_a.ins_to_mem); else n_pass++;
        n_checks++; if (log_a.size() != 3) $display("FAIL rstmid_nwr got=%0d exp=3", log_a.size()); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        sent_a.delete();
        log_a.delete();
        w = rand_word();
        send_word(1'b0, w, 1, 1'b0);
        send_word(1'b0, 32'hFFFF_FFFF, 1, 1'b1);
        repeat (3) @(posedge clk); #1;
        build_model(1'b0);
        n_checks++; if (log_a.size() != exp_q.size()) $display("FAIL rstmid_nwr2 got=%0d exp=%0d", log_a.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_a.size()) ? log_a[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL rstmid_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        wr_t got;
        sent_b.delete();
        log_b.delete();
        for (int k = 0; k < 4; k++) send_word(1'b1, rand_word(), 2, k == 3);
        @(negedge clk);
        n_checks++; if (bus_b.wr_ram_inst !== 1'b1) $display("FAIL ovf_wr got=%b exp=1", bus_b.wr_ram_inst); else n_pass++;
        n_checks++; if (bus_b.addr_mem_inst !== 2'd3) $display("FAIL ovf_addr got=%0d exp=3", bus_b.addr_mem_inst); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus_b.ctrl_clk_mips !== 1'b0) $display("FAIL ovf_clk got=%b exp=0", bus_b.ctrl_clk_mips); else n_pass++;
        n_checks++; if (bus_b.word_count !== 3'd4) $display("FAIL ovf_wc got=%0d exp=4", bus_b.word_count); else n_pass++;
        @(posedge clk); #1;
        send_word(1'b1, rand_word(), 0, 1'b0);
        repeat (2) @(posedge clk); #1;
        build_model(1'b1);
        n_checks++; if (bus_b.load_err !== exp_err) $display("FAIL ovf_err got=%b exp=%b", bus_b.load_err, exp_err); else n_pass++;
        n_checks++; if (bus_b.load_done !== exp_done) $display("FAIL ovf_done got=%b exp=%b", bus_b.load_done, exp_done); else n_pass++;
        n_checks++; if (log_b.size() != exp_q.size()) $display("FAIL ovf_nwr got=%0d exp=%0d", log_b.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_b.size()) ? log_b[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL ovf_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        pulse_req(1'b1, 1'b0, 8'h00);
        sent_b.delete();
        log_b.delete();
        @(negedge clk);
        n_checks++; if (bus_b.load_err !== 1'b0) $display("FAIL ovf_clr_err got=%b exp=0", bus_b.load_err); else n_pass++;
        n_checks++; if (bus_b.word_count !== 3'd0) $display("FAIL ovf_clr_wc got=%0d exp=0", bus_b.word_count); else n_pass++;
        @(posedge clk); #1;
        send_word(1'b1, 32'hFFFF_FFFF, 0, 1'b1);
        repeat (3) @(posedge clk); #1;
        build_model(1'b1);
        n_checks++; if (bus_b.load_done !== exp_done) $display("FAIL ovf_rel_done got=%b exp=%b", bus_b.load_done, exp_done); else n_pass++;
        n_checks++; if (log_b.size() != exp_q.size()) $display("FAIL ovf_rel_nwr got=%0d exp=%0d", log_b.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = (i < log_b.size()) ? log_b[i] : '0;
            n_checks++; if (got !== exp_q[i]) $display("FAIL ovf_rel_wr[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.rx_done_tick = 1'b0; bus_a.rx_data_in = 8'h00; bus_a.load_req = 1'b0;
        bus_b.rx_done_tick = 1'b0; bus_b.rx_data_in = 8'h00; bus_b.load_req = 1'b0;
        test_reset();
        test_basic();
        test_reload();
        test_back_to_back();
        test_req_mid_word();
        test_reset_mid();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
